// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, grant/clear-state encodings and the scanout address helper.
// The 320-wide row stride is built from two shifts so no multiplier is inferred.
package fb_pkg;

  localparam int FB_W    = 320;
  localparam int FB_H    = 240;
  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 8;
  localparam int FB_SIZE = FB_W * FB_H;

  localparam logic [ADDR_W-1:0] FB_SIZE_A = ADDR_W'(FB_SIZE);
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(FB_SIZE - 1);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_SCAN,
    GNT_CLR,
    GNT_WR
  } gnt_e;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_RUN,
    CLR_DONE
  } clr_state_e;

  // Screen coordinates are pixel-doubled: halve both, then row*320 = (row<<8)+(row<<6).
  function automatic logic [ADDR_W-1:0] fb_scan_addr(input logic [9:0] x, input logic [8:0] y);
    logic [ADDR_W-1:0] yh;
    logic [ADDR_W-1:0] xh;
    yh = ADDR_W'(y >> 1);
    xh = ADDR_W'(x >> 1);
    return (yh << 8) + (yh << 6) + xh;
  endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Screen-clear engine: writes a latched colour to every pixel, one pixel per granted cycle.
// Requests continuously while running; o_done is registered and trails the last write by a cycle.
module fb_clear_engine
  import fb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_start_data,
  input  logic              i_gnt,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_hold,
  output logic              o_done
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] colour_q, colour_d;
  logic              done_q, done_d;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    colour_d = colour_q;
    done_d   = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (i_start) begin
          colour_d = i_start_data;
          ptr_d    = '0;
          state_d  = CLR_RUN;
        end
      end
      CLR_RUN: begin
        if (i_gnt) begin
          ptr_d = ptr_q + ADDR_W'(1);
          if (ptr_q == LAST_PIX) begin
            state_d = CLR_DONE;
          end
        end
      end
      CLR_DONE: begin
        done_d  = 1'b1;
        state_d = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= CLR_IDLE;
      ptr_q    <= '0;
      colour_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      colour_q <= colour_d;
      done_q   <= done_d;
    end
  end

  assign o_req  = (state_q == CLR_RUN);
  assign o_busy = (state_q == CLR_RUN);
  // Writer stays locked out through the DONE cycle so its ack cannot land with the done pulse.
  assign o_hold = (state_q != CLR_IDLE);
  assign o_addr = ptr_q;
  assign o_data = colour_q;
  assign o_done = done_q;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout > clear > writer, one registered RAM access per cycle.
// Scanout pixel appears 3 edges after its strobe; writer/clear stall (never drop) while outranked or gated.
module fb_arbiter
  import fb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_stb,
  input  logic              i_active,
  input  logic              i_vblank,
  input  logic [9:0]        i_x,
  input  logic [8:0]        i_y,
  input  logic              i_vsync_only,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_clr_req,
  input  logic [DATA_W-1:0] i_clr_data,
  output logic              o_clr_busy,
  output logic              o_clr_done,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [DATA_W-1:0] o_pix_data
);

  gnt_e              gnt;
  logic              scan_q, scan_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd1_q, rd1_d;
  logic              rd2_q, rd2_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic              wr_ok;
  logic              clr_req;
  logic              clr_gnt;
  logic              clr_hold;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;

  fb_clear_engine u_clear (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_clr_req),
    .i_start_data (i_clr_data),
    .i_gnt        (clr_gnt),
    .o_req        (clr_req),
    .o_addr       (clr_addr),
    .o_data       (clr_data),
    .o_busy       (o_clr_busy),
    .o_hold       (clr_hold),
    .o_done       (o_clr_done)
  );

  assign clr_gnt = (gnt == GNT_CLR);

  always_comb begin
    scan_d      = i_pix_stb & i_active & ~i_x[0];
    scan_addr_d = scan_d ? fb_scan_addr(i_x, i_y) : scan_addr_q;
    wr_ok       = ~i_vsync_only | i_vblank;

    // wr_ack_q masks the writer's still-held request in its ack cycle; i_clr_req wins a tie in IDLE.
    gnt = GNT_NONE;
    if (scan_q) begin
      gnt = GNT_SCAN;
    end else if (clr_req && wr_ok) begin
      gnt = GNT_CLR;
    end else if (i_wr_req && wr_ok && !wr_ack_q && !clr_hold && !i_clr_req) begin
      gnt = GNT_WR;
    end

    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    wr_ack_d    = 1'b0;
    case (gnt)
      GNT_SCAN: begin
        ram_en_d   = 1'b1;
        ram_addr_d = scan_addr_q;
      end
      GNT_CLR: begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = clr_addr;
        ram_wdata_d = clr_data;
      end
      GNT_WR: begin
        wr_ack_d = 1'b1;
        if (i_wr_addr < FB_SIZE_A) begin
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = i_wr_addr;
          ram_wdata_d = i_wr_data;
        end
      end
      default: ;
    endcase

    rd1_d = (gnt == GNT_SCAN);
    rd2_d = rd1_q;
    pix_d = rd2_q ? i_ram_rdata : pix_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scan_q      <= 1'b0;
      scan_addr_q <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      rd1_q       <= 1'b0;
      rd2_q       <= 1'b0;
      pix_q       <= '0;
    end else begin
      scan_q      <= scan_d;
      scan_addr_q <= scan_addr_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      wr_ack_q    <= wr_ack_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      pix_q       <= pix_d;
    end
  end

  assign o_ram_en    = ram_en_q;
  assign o_ram_we    = ram_we_q;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_wdata = ram_wdata_q;
  assign o_wr_ack    = wr_ack_q;
  assign o_pix_data  = pix_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural 1-cycle-latency framebuffer RAM.
module tb_fb_arbiter;
  import fb_pkg::*;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_pix_stb = 1'b0;
  logic              i_active = 1'b0;
  logic              i_vblank = 1'b0;
  logic [9:0]        i_x = '0;
  logic [8:0]        i_y = '0;
  logic              i_vsync_only = 1'b0;
  logic              i_wr_req = 1'b0;
  logic [ADDR_W-1:0] i_wr_addr = '0;
  logic [DATA_W-1:0] i_wr_data = '0;
  logic              o_wr_ack;
  logic              i_clr_req = 1'b0;
  logic [DATA_W-1:0] i_clr_data = '0;
  logic              o_clr_busy;
  logic              o_clr_done;
  logic              o_ram_en;
  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_wdata;
  logic [DATA_W-1:0] i_ram_rdata;
  logic [DATA_W-1:0] o_pix_data;

  logic [7:0]        mem [0:131071];
  logic              pre_en = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [7:0]        pre_dat = '0;
  logic [ADDR_W-1:0] last_wa = '0;
  int n_wr = 0, n_rd = 0, n_jump = 0, n_done = 0, n_coinc = 0;
  int n_vec = 0, n_err = 0;

  always #5 i_clk = ~i_clk;

  fb_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_active(i_active),
    .i_vblank(i_vblank), .i_x(i_x), .i_y(i_y), .i_vsync_only(i_vsync_only),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_ack(o_wr_ack),
    .i_clr_req(i_clr_req), .i_clr_data(i_clr_data), .o_clr_busy(o_clr_busy),
    .o_clr_done(o_clr_done), .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata),
    .o_pix_data(o_pix_data)
  );

  // RAM plus access monitor; a "jump" is any write not at previous write address + 1.
  always @(posedge i_clk) begin
    if (pre_en) mem[pre_addr] <= pre_dat;
    if (o_ram_en) begin
      if (o_ram_we) begin
        mem[o_ram_addr] <= o_ram_wdata;
        n_wr++;
        if (o_ram_addr != last_wa + 17'd1) n_jump++;
        last_wa = o_ram_addr;
      end else begin
        i_ram_rdata <= mem[o_ram_addr];
        n_rd++;
      end
    end
    if (o_clr_done) n_done++;
    if (o_wr_ack && o_ram_en && !o_ram_we) n_coinc++;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_addr = a; pre_dat = d;
    step();
    pre_en = 1'b0;
  endtask

  initial begin
    int ack_k, n_ack, w0, r0, j0, d0, wr_at_done, j_at_done, done_t, ack_t, early, busy1;
    logic [ADDR_W-1:0] last_at_done;

    // Reset state
    step(); step();
    chk("rst_ram_en", o_ram_en, 0);
    chk("rst_ram_we", o_ram_we, 0);
    chk("rst_ram_addr", o_ram_addr, 0);
    chk("rst_ram_wdata", o_ram_wdata, 0);
    chk("rst_wr_ack", o_wr_ack, 0);
    chk("rst_clr_busy", o_clr_busy, 0);
    chk("rst_clr_done", o_clr_done, 0);
    chk("rst_pix", o_pix_data, 0);
    preload(17'd1607, 8'hA5);
    i_rst = 1'b0;
    step();

    // Scanout fetch of (14,10) -> 5*320+7 = 1607
    i_active = 1; i_pix_stb = 1; i_x = 10'd14; i_y = 9'd10;
    step();
    i_active = 0; i_pix_stb = 0;
    step();
    chk("scan_en_n1", o_ram_en, 1);
    chk("scan_we_n1", o_ram_we, 0);
    chk("scan_addr_n1", o_ram_addr, 1607);
    step();
    chk("pix_not_yet_n2", o_pix_data, 0);
    step();
    chk("pix_n3", o_pix_data, 8'hA5);
    step(); step();
    chk("pix_hold", o_pix_data, 8'hA5);

    // Odd x gives no fetch; bottom-right doubled pixel maps to the last address
    i_active = 1; i_pix_stb = 1; i_x = 10'd15;
    step();
    i_x = 10'd638; i_y = 9'd479;
    step();
    i_active = 0; i_pix_stb = 0;
    chk("odd_x_no_read", o_ram_en, 0);
    step();
    chk("scan_addr_last", o_ram_addr, 76799);
    step(); step(); step();

    // Writer contention with continuous scanout (fetch on every even x)
    r0 = n_rd; w0 = n_wr; n_ack = 0; ack_k = -1;
    i_active = 1; i_pix_stb = 1; i_y = 9'd20;
    for (int k = 0; k < 24; k++) begin
      i_x = 10'(k);
      if (k == 3) begin i_wr_req = 1; i_wr_addr = 17'd100; i_wr_data = 8'h3C; end
      step();
      if (o_wr_ack) begin
        n_ack++;
        if (ack_k < 0) ack_k = k;
        i_wr_req = 0;
      end
    end
    i_active = 0; i_pix_stb = 0;
    step(); step(); step();
    chk("cont_ack_cycle", ack_k, 4);
    chk("cont_ack_count", n_ack, 1);
    chk("cont_write_count", n_wr - w0, 1);
    chk("cont_mem100", mem[100], 8'h3C);
    chk("cont_ack_vs_scan", n_coinc, 0);
    chk("cont_scan_reads", n_rd - r0, 12);

    // Tear-free gating: nothing until vblank, then ack on the next cycle
    w0 = n_wr; n_ack = 0;
    i_vsync_only = 1; i_vblank = 0;
    i_wr_req = 1; i_wr_addr = 17'd200; i_wr_data = 8'h5A;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (o_wr_ack) n_ack++;
    end
    chk("vs_no_ack", n_ack, 0);
    chk("vs_no_write", n_wr - w0, 0);
    i_vblank = 1;
    step();
    chk("vs_ack_on_vblank", o_wr_ack, 1);
    i_wr_req = 0;
    step();
    chk("vs_single_ack", o_wr_ack, 0);
    step();
    chk("vs_mem200", mem[200], 8'h5A);
    i_vsync_only = 0; i_vblank = 0;

    // Out-of-range write: acked, never issued
    w0 = n_wr;
    i_wr_req = 1; i_wr_addr = 17'd76800; i_wr_data = 8'hFF;
    step();
    chk("oor_ack", o_wr_ack, 1);
    chk("oor_ram_en", o_ram_en, 0);
    i_wr_req = 0;
    step();
    chk("oor_no_write", n_wr - w0, 0);

    // Full clear with a concurrent writer request
    w0 = n_wr; j0 = n_jump; d0 = n_done;
    done_t = 0; ack_t = 0; early = 0; busy1 = 0;
    wr_at_done = 0; j_at_done = 0; last_at_done = '0;
    i_clr_req = 1; i_clr_data = 8'h00;
    i_wr_req = 1; i_wr_addr = 17'd300; i_wr_data = 8'h77;
    for (int t = 1; t <= 80000 && ack_t == 0; t++) begin
      step();
      if (t == 1) begin i_clr_req = 0; busy1 = int'(o_clr_busy); end
      if (o_clr_done && done_t == 0) begin
        done_t = t; wr_at_done = n_wr - w0; j_at_done = n_jump - j0; last_at_done = last_wa;
      end
      if (o_wr_ack) begin
        if (done_t == 0) early++;
        ack_t = t; i_wr_req = 0;
      end
    end
    step(); step();
    chk("clr_busy", busy1, 1);
    chk("clr_done_cycle", done_t, 76802);
    chk("clr_write_count", wr_at_done, 76800);
    chk("clr_one_run", j_at_done, 1);
    chk("clr_last_addr", last_at_done, 76799);
    chk("clr_no_early_ack", early, 0);
    chk("clr_ack_after_done", (ack_t > done_t), 1);
    chk("clr_done_pulses", n_done - d0, 1);
    chk("clr_mem0", mem[0], 8'h00);
    chk("clr_mem_last", mem[76799], 8'h00);
    chk("clr_then_wr", mem[300], 8'h77);

    // Reset mid-clear aborts silently
    d0 = n_done;
    i_clr_req = 1; i_clr_data = 8'h44;
    step();
    i_clr_req = 0;
    repeat (501) step();
    chk("abort_busy_before", o_clr_busy, 1);
    i_rst = 1;
    step();
    i_rst = 0;
    chk("abort_busy", o_clr_busy, 0);
    chk("abort_ram_en", o_ram_en, 0);
    chk("abort_done", o_clr_done, 0);
    w0 = n_wr;
    repeat (20) step();
    chk("abort_no_writes", n_wr - w0, 0);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_busy_stays", o_clr_busy, 0);
    chk("abort_mem_untouched", mem[1000], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
